// File: rtl/dac_spi_writer.sv
// rtl/dac_spi_writer.sv - 12-bit sample to LTC2624 32-bit SPI write-and-update serialiser
//
// Purpose: takes one-cycle sample strobes from the envelope follower and sends
// each sample as {8'h00, DAC_CMD, DAC_ADDR, sample, 4'h0}, MSB first, with a
// one-entry pending buffer (latest sample wins while the bus is busy).
//
// Ports:
//   CLK_50MHZ      in   system clock, rising edge
//   RESET          in   asynchronous active-high reset
//   inSample       in   12-bit unsigned sample
//   inSampleReady  in   one-cycle strobe qualifying inSample
//   outBusy        out  frame in progress or CS gap being enforced
//   outDropped     out  one-cycle pulse when the pending sample is overwritten
//   SPI_SCK        out  SPI clock, idle low
//   SPI_MOSI       out  SPI data, MSB first, changes on SCK falling edge
//   DAC_CS         out  chip select, active low
//   DAC_CLR        out  DAC clear, active low, released one edge after reset
module dac_spi_writer #(
    parameter int         CLK_DIV  = 2,
    parameter logic [3:0] DAC_CMD  = 4'b0011,
    parameter logic [3:0] DAC_ADDR = 4'b1111,
    parameter int         CS_GAP   = 2
) (
    input  logic        CLK_50MHZ,
    input  logic        RESET,
    input  logic [11:0] inSample,
    input  logic        inSampleReady,
    output logic        outBusy,
    output logic        outDropped,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  gap_q, gap_d;
    logic [4:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic [31:0] shreg_q, shreg_d;
    logic        busy_q, busy_d;
    logic        pend_v_q, pend_v_d;
    logic [11:0] pend_q, pend_d;
    logic        drop_q, drop_d;
    logic        clr_q, clr_d;

    logic        load_en;
    logic [11:0] load_smp;

    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            drop_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            cs_q     <= cs_d;
            shreg_q  <= shreg_d;
            busy_q   <= busy_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        gap_d    = gap_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        cs_d     = cs_q;
        shreg_d  = shreg_q;
        busy_d   = busy_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        drop_d   = 1'b0;
        clr_d    = 1'b1;
        load_en  = 1'b0;
        load_smp = inSample;

        case (state_q)
            IDLE: begin
                if (inSampleReady) begin
                    load_en = 1'b1;
                    // Older pending sample goes first; the new one waits.
                    if (pend_v_q) begin
                        load_smp = pend_q;
                        pend_d   = inSample;
                    end
                end else if (pend_v_q) begin
                    load_en  = 1'b1;
                    load_smp = pend_q;
                    pend_v_d = 1'b0;
                end
            end
            SHIFT: begin
                if (inSampleReady) begin
                    pend_d   = inSample;
                    pend_v_d = 1'b1;
                    drop_d   = pend_v_q;
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else if (bit_q == 5'd0) begin
                        sck_d   = 1'b0;
                        cs_d    = 1'b1;
                        shreg_d = '0;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        // Falling SCK edge: next bit appears on MOSI.
                        sck_d   = 1'b0;
                        bit_d   = bit_q - 5'd1;
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (pend_v_q) begin
                        load_en  = 1'b1;
                        load_smp = pend_q;
                        pend_v_d = inSampleReady;
                        pend_d   = inSample;
                    end else begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        pend_v_d = inSampleReady;
                        pend_d   = inSample;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                    if (inSampleReady) begin
                        pend_d   = inSample;
                        pend_v_d = 1'b1;
                        drop_d   = pend_v_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d = SHIFT;
            shreg_d = {8'h00, DAC_CMD, DAC_ADDR, load_smp, 4'h0};
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            div_d   = '0;
            bit_d   = 5'd31;
            busy_d  = 1'b1;
        end
    end

    always_comb begin
        outBusy    = busy_q;
        outDropped = drop_q;
        SPI_SCK    = sck_q;
        SPI_MOSI   = shreg_q[31];
        DAC_CS     = cs_q;
        DAC_CLR    = clr_q;
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// tb/tb_dac_spi_writer.sv - randomized self-checking bench for dac_spi_writer
module tb_dac_spi_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [11:0] smp;
    logic        busy0, drop0, sck0, mosi0, cs0, clr0;
    logic        busy1, drop1, sck1, mosi1, cs1, clr1;

    always #10 clk = ~clk;

    dac_spi_writer #(.CLK_DIV(2), .DAC_CMD(4'b0011), .DAC_ADDR(4'b1111), .CS_GAP(2)) u0 (
        .CLK_50MHZ(clk), .RESET(rst), .inSample(smp), .inSampleReady(stb),
        .outBusy(busy0), .outDropped(drop0), .SPI_SCK(sck0), .SPI_MOSI(mosi0),
        .DAC_CS(cs0), .DAC_CLR(clr0));

    dac_spi_writer #(.CLK_DIV(1), .DAC_CMD(4'b0011), .DAC_ADDR(4'b1111), .CS_GAP(1)) u1 (
        .CLK_50MHZ(clk), .RESET(rst), .inSample(smp), .inSampleReady(stb),
        .outBusy(busy1), .outDropped(drop1), .SPI_SCK(sck1), .SPI_MOSI(mosi1),
        .DAC_CS(cs1), .DAC_CLR(clr1));

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level view. A frame sent at edge S keeps CS low
    // for 64*D edges and the writer becomes free again at edge S+64*D+G.
    int          m_div [2] = '{2, 1};
    int          m_gap [2] = '{2, 1};
    bit          m_act [2];
    int          m_s   [2];
    int          m_e   [2];
    bit          m_pv  [2];
    logic [11:0] m_pd  [2];
    logic [31:0] m_word[2];
    bit          m_drop[2];
    bit          m_clr;
    int          t;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic logic [31:0] mk_word(input logic [11:0] s);
        return {8'h00, 4'h3, 4'hF, s, 4'h0};
    endfunction

    task automatic m_send(input int i, input logic [11:0] s);
        m_act[i]  = 1'b1;
        m_s[i]    = t;
        m_e[i]    = t + 64 * m_div[i] + m_gap[i];
        m_word[i] = mk_word(s);
        if (i == 0) q0.push_back(m_word[i]);
        else        q1.push_back(m_word[i]);
    endtask

    task automatic m_edge(input int i, input bit st, input logic [11:0] s);
        m_drop[i] = 1'b0;
        if (!m_act[i]) begin
            if (st) begin
                if (m_pv[i]) begin
                    m_send(i, m_pd[i]);
                    m_pd[i] = s;
                end else begin
                    m_send(i, s);
                end
            end else if (m_pv[i]) begin
                m_send(i, m_pd[i]);
                m_pv[i] = 1'b0;
            end
        end else if (t == m_e[i]) begin
            if (m_pv[i]) m_send(i, m_pd[i]);
            else         m_act[i] = 1'b0;
            m_pv[i] = st;
            m_pd[i] = s;
        end else if (st) begin
            m_drop[i] = m_pv[i];
            m_pv[i]   = 1'b1;
            m_pd[i]   = s;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_pv[i]   = 1'b0;
            m_drop[i] = 1'b0;
        end
        m_clr = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_out(input int i);
        int          k;
        bit          low;
        logic [31:0] w;
        logic        cs, sck, mo, bu, dr, cl;
        if (i == 0) {cs, sck, mo, bu, dr, cl} = {cs0, sck0, mosi0, busy0, drop0, clr0};
        else        {cs, sck, mo, bu, dr, cl} = {cs1, sck1, mosi1, busy1, drop1, clr1};
        k   = t - m_s[i];
        low = m_act[i] && (k < 64 * m_div[i]);
        w   = m_word[i];
        check_eq($sformatf("cs%0d", i), cs, !low);
        check_eq($sformatf("sck%0d", i), sck, low && ((k / m_div[i]) % 2 == 1));
        check_eq($sformatf("mosi%0d", i), mo, low ? w[31 - k / (2 * m_div[i])] : 1'b0);
        check_eq($sformatf("busy%0d", i), bu, m_act[i]);
        check_eq($sformatf("drop%0d", i), dr, m_drop[i]);
        check_eq($sformatf("clr%0d", i), cl, m_clr);
    endtask

    task automatic step(input bit st, input logic [11:0] s);
        stb = st;
        smp = s;
        @(posedge clk);
        t++;
        if (rst) begin
            m_reset();
        end else begin
            m_edge(0, st, s);
            m_edge(1, st, s);
            m_clr = 1'b1;
        end
        @(negedge clk);
        stb = 1'b0;
        chk_out(0);
        chk_out(1);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 12'h000);
    endtask

    // SPI-side decode: capture MOSI on SCK rising edges of each CS-low window.
    logic [31:0] cap0, cap1;
    int          n0, n1;

    always @(negedge cs0) n0 = 0;
    always @(negedge cs1) n1 = 0;
    always @(posedge sck0) if (!cs0) begin cap0 = {cap0[30:0], mosi0}; n0++; end
    always @(posedge sck1) if (!cs1) begin cap1 = {cap1[30:0], mosi1}; n1++; end

    always @(posedge cs0) if (!rst) begin
        check_eq("frame0_bits", n0, 32);
        check_eq("frame0_queued", q0.size(), 1);
        if (q0.size() > 0) check_eq("frame0_word", cap0, q0.pop_front());
    end

    always @(posedge cs1) if (!rst) begin
        check_eq("frame1_bits", n1, 32);
        check_eq("frame1_queued", q1.size(), 1);
        if (q1.size() > 0) check_eq("frame1_word", cap1, q1.pop_front());
    end

    initial begin
        rst = 1'b1;
        stb = 1'b0;
        smp = '0;
        t   = 0;
        m_reset();
        #1;
        chk_out(0);
        chk_out(1);
        idle(3);
        rst = 1'b0;
        idle(20);

        // single frame 003FABC0
        step(1'b1, 12'hABC);
        idle(150);

        // back-to-back frames through the pending buffer
        step(1'b1, 12'h001);
        idle(9);
        step(1'b1, 12'h002);
        idle(300);

        // latest sample wins: 0x200 is dropped by 0x300
        step(1'b1, 12'h100);
        idle(19);
        step(1'b1, 12'h200);
        idle(19);
        step(1'b1, 12'h300);
        idle(300);

        // reset in the middle of a frame, around the tenth SCK edge
        step(1'b1, 12'h123);
        idle(21);
        #5 rst = 1'b1;
        #1;
        check_eq("async_cs", cs0, 1'b1);
        check_eq("async_sck", sck0, 1'b0);
        check_eq("async_busy", busy0, 1'b0);
        m_reset();
        @(negedge clk);
        chk_out(0);
        chk_out(1);
        idle(2);
        rst = 1'b0;
        step(1'b1, 12'hFFF);
        idle(200);

        // randomized strobe density, from every cycle to sparse
        for (int blk = 0; blk < 8; blk++) begin
            int per;
            per = $urandom_range(1, 300);
            for (int c = 0; c < 500; c++)
                step($urandom_range(0, per - 1) == 0, 12'($urandom));
        end
        idle(300);

        check_eq("q0_drained", q0.size(), 0);
        check_eq("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_spi_writer.md
Name: dac_spi_writer

Overview:
Final audio stage. It sits directly downstream of the envelope follower and consumes its 12-bit sample and sample-ready strobe. Each accepted sample is serialised as a 32-bit write-and-update command to the board's LTC2624 SPI DAC. One-entry pending buffer; latest sample wins when the bus is busy.

Parameters:
CLK_DIV, 2, system clocks per SCK half-period (min 1); default gives SCK = 12.5 MHz
DAC_CMD, 4'b0011, LTC2624 command nibble (write and update)
DAC_ADDR, 4'b1111, LTC2624 address nibble (all channels)
CS_GAP, 2, minimum clocks DAC_CS held high between frames (min 1)

Ports:
CLK_50MHZ  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-high reset
inSample  input  12  unsigned sample from envelope follower
inSampleReady  input  1  one-cycle strobe; inSample valid in same cycle
outBusy  output  1  high while a frame is in progress or gap is being enforced
outDropped  output  1  one-cycle pulse when a pending sample is overwritten
SPI_SCK  output  1  SPI clock, idle low
SPI_MOSI  output  1  SPI data, MSB first
DAC_CS  output  1  DAC chip select, active low
DAC_CLR  output  1  DAC async clear, active low

Behaviour:
- Reset (async, immediate): DAC_CS=1, SPI_SCK=0, SPI_MOSI=0, DAC_CLR=0, outBusy=0, outDropped=0. Pending buffer empty, state IDLE. DAC_CLR goes to 1 on the first clock edge after RESET deasserts.
- Reset mid-frame: the frame is abandoned. DAC_CS rises asynchronously and no partial word is completed.
- Frame word: {8'h00, DAC_CMD, DAC_ADDR, sample[11:0], 4'h0}, 32 bits, shifted out bit 31 first.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Strobe seen at edge N: the word is loaded, DAC_CS=0, SPI_SCK=0, SPI_MOSI=bit31, outBusy=1, all valid after edge N, and the state moves to SHIFT.
  - If no strobe but the pending buffer is full, the same load happens from the pending buffer, which then empties.
- SHIFT:
  - Each bit takes CLK_DIV clocks with SCK low, then CLK_DIV clocks with SCK high.
  - MOSI changes only on the SCK falling edge (or at load), so it is stable around the SCK rising edge.
  - After bit 0's high phase: SCK=0, DAC_CS=1, state GAP.
  - CS is low for exactly 64*CLK_DIV clocks (128 by default).
- GAP:
  - DAC_CS stays high for CS_GAP clocks.
  - Then, if the pending buffer is full, go to the IDLE load action directly (outBusy stays 1). Otherwise go to IDLE with outBusy=0.
- Strobe while outBusy=1: the sample is stored in the pending buffer.
  - If the buffer was already full, it is overwritten and outDropped pulses high for that one cycle.
  - The frame in flight is never altered.
- Strobe in the same cycle that GAP exits to a pending load: the pending sample is transmitted and the new strobe sample becomes pending (no drop).
- Strobe in IDLE with the pending buffer empty: sent directly, no buffering.
- Throughput at defaults: 128+2+1 clocks per frame, about 382 kHz max sample rate. Any strobe rate up to this is lossless.
- Sample is sent unmodified; there is no clipping or scaling.

Test Plan:
- Reset release, no strobes → DAC_CS=1, SCK=0, MOSI=0, outBusy=0 indefinitely; DAC_CLR=0 during RESET, 1 from the first edge after.
- Single strobe, inSample=12'hABC → one frame; the bench samples MOSI on 32 SCK rising edges and sees 32'h003FABC0; CS low exactly 128 clocks; outBusy falls 2 clocks after CS rises.
- Strobes of 12'h001 then 12'h002, 10 clocks apart → two back-to-back frames 003F0010 and 003F0020; CS high exactly CS_GAP=2 clocks between them; no outDropped.
- Three strobes (12'h100, 12'h200, 12'h300) during one frame, the first starting it → frames 003F1000 then 003F3000; one outDropped pulse, at the 12'h300 strobe.
- RESET asserted at SCK edge 10 of a frame → DAC_CS=1 and SCK=0 within the same cycle; after release with a strobe of 12'hFFF, a complete clean frame 003FFFF0 is sent.
- CLK_DIV=1, CS_GAP=1 build, strobe 12'h555 → SCK period 2 clocks, CS low 64 clocks, word 003F5550.
